systolic_result_drain: RTL
==========================

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning array dimension (rows and columns).
REQ-002 SHALL have parameter O_BITS, default 16, meaning width of one result element.
REQ-003 SHALL have port i_clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port i_c_full  input  SIZE*SIZE*O_BITS  meaning flat result matrix; element k = row*SIZE+col at bits [O_BITS*k +: O_BITS].
REQ-006 SHALL have port i_capture  input  1  meaning single-cycle pulse: i_c_full holds a complete result this cycle.
REQ-007 SHALL have port i_rows  input  clog2(SIZE)+1  meaning number of rows to drain, sampled with i_capture; 0 or >SIZE means SIZE.
REQ-008 SHALL have port i_ready  input  1  meaning downstream accepts o_data this cycle.
REQ-009 SHALL have port o_data  output  SIZE*O_BITS  meaning one result row; column c at bits [O_BITS*c +: O_BITS].
REQ-010 SHALL have port o_valid  output  1  meaning o_data/o_row/o_last are valid.
REQ-011 SHALL have port o_row  output  clog2(SIZE)  meaning index of the row on o_data.
REQ-012 SHALL have port o_last  output  1  meaning current row is the final row of the frame.
REQ-013 SHALL have port o_busy  output  1  meaning a frame is held and not fully drained.
REQ-014 SHALL have port o_overrun  output  1  meaning sticky flag: a capture was dropped.

Function
REQ-015 SHALL implement FSM states IDLE and STREAM; IDLE -> STREAM on accepted capture; STREAM -> IDLE on transfer of last row with no same-cycle capture.
REQ-016 SHALL accept a capture when i_capture=1 and (state=IDLE or (o_valid & i_ready & o_last)); accepted capture copies i_c_full into an internal shadow register, latches row count, resets row counter to 0.
REQ-017 SHALL assert o_valid in the cycle after an accepted capture (latency 1), presenting row 0.
REQ-018 SHALL define transfer as o_valid=1 and i_ready=1 at a rising edge; on transfer of a non-last row, row counter increments by 1 and the next row appears the following cycle.
REQ-019 SHALL hold o_data, o_row, o_last stable while o_valid=1 and i_ready=0; o_valid SHALL NOT drop without a transfer.
REQ-020 SHALL drive o_last=1 exactly when o_valid=1 and o_row = latched row count - 1.
REQ-021 SHALL, on last-row transfer with simultaneous accepted capture, present row 0 of the new frame next cycle with no bubble.
REQ-022 SHALL ignore i_capture while STREAM unless REQ-016 applies; shadow register unchanged; o_overrun set to 1 next cycle and held until reset.
REQ-023 SHALL drive o_busy = 1 iff state=STREAM; o_valid = o_busy.
REQ-024 SHALL drive o_data to all zeros while o_valid=0.
REQ-025 SHALL be insensitive to i_c_full except in the capture-accept cycle.

Reset
REQ-026 SHALL, on i_reset=0 at any time, immediately force state IDLE, o_valid=0, o_busy=0, o_last=0, o_row=0, o_data=0, o_overrun=0, row count=SIZE, shadow register=0.
REQ-027 SHALL discard any partially drained frame on reset; after release, no output until a new capture.
REQ-028 SHALL ignore i_capture in the cycle reset is asserted.

Verification (SIZE=4, O_BITS=16)
REQ-029 SHALL verify basic drain: i_c_full element k = k+1, i_capture pulse, i_rows=4, i_ready=1 -> rows 0..3 on consecutive cycles starting 1 cycle later, row 2 = {12,11,10,9}, o_last on row 3 only, then o_valid=0.
REQ-030 SHALL verify backpressure: i_ready=0 for 3 cycles during row 1 -> o_data/o_row held at row 1 = {8,7,6,5}, no skipped or duplicated rows.
REQ-031 SHALL verify partial frame and size rule: i_rows=2 -> exactly rows 0,1, o_last on row 1; i_rows=0 -> 4 rows.
REQ-032 SHALL verify overrun: second i_capture with different data during row 1 -> o_overrun=1 next cycle, remaining rows from first frame, flag stays 1.
REQ-033 SHALL verify back-to-back: capture coincident with last-row transfer -> next cycle row 0 of new frame, o_overrun stays 0.
REQ-034 SHALL verify reset mid-frame: i_reset=0 during row 2 -> all outputs 0 immediately, no output after release until new capture.

Source files
------------

// File: rtl/systolic_result_drain.sv
// Systolic result drain: shadows one finished result matrix and streams
// it out one row per valid/ready transfer.
module systolic_result_drain #(
   parameter int SIZE   = 32,
   parameter int O_BITS = 16
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [SIZE*SIZE*O_BITS-1:0] i_c_full,
   input  logic                        i_capture,
   input  logic [$clog2(SIZE):0]       i_rows,
   input  logic                        i_ready,
   output logic [SIZE*O_BITS-1:0]      o_data,
   output logic                        o_valid,
   output logic [$clog2(SIZE)-1:0]     o_row,
   output logic                        o_last,
   output logic                        o_busy,
   output logic                        o_overrun
);

   localparam int RW = $clog2(SIZE);
   localparam int CW = RW + 1;
   localparam int RB = SIZE * O_BITS;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;

   logic [0:0]                  r_state;
   logic [RW-1:0]               r_row;
   logic [CW-1:0]               r_count;
   logic [SIZE*SIZE*O_BITS-1:0] r_shadow;
   logic                        r_overrun;

   logic          w_stream;
   logic          w_last;
   logic          w_xfer;
   logic          w_accept;
   logic [CW-1:0] w_rows;
   logic [RB-1:0] w_row_data;

   assign w_stream = (r_state == STREAM);
   assign w_last   = w_stream && ({1'b0, r_row} == (r_count - CW'(1)));
   assign w_xfer   = w_stream & i_ready;
   // A capture lands only when the shadow is free or frees up this edge.
   assign w_accept = i_capture & (~w_stream | (w_xfer & w_last));
   assign w_rows   = ((i_rows == '0) || (i_rows > CW'(SIZE)))
                     ? CW'(SIZE) : i_rows;

   // Select the current row out of the shadowed matrix.
   always_comb begin
      w_row_data = '0;
      for (int r = 0; r < SIZE; r++) begin
         if (r_row == RW'(r)) begin
            w_row_data = r_shadow[r*RB +: RB];
         end
      end
   end

   // Frame sequencing: state, row pointer and latched row count.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_count <= CW'(SIZE);
      end else if (w_accept) begin
         r_state <= STREAM;
         r_row   <= '0;
         r_count <= w_rows;
      end else if (w_xfer) begin
         if (w_last) begin
            r_state <= IDLE;
            r_row   <= '0;
         end else begin
            r_row <= r_row + RW'(1);
         end
      end
   end

   // Shadow copy of the result matrix, loaded only on accepted capture.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_shadow <= '0;
      end else if (w_accept) begin
         r_shadow <= i_c_full;
      end
   end

   // Sticky flag for captures that arrived while a frame was held.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_overrun <= 1'b0;
      end else if (i_capture && !w_accept) begin
         r_overrun <= 1'b1;
      end
   end

   assign o_valid   = w_stream;
   assign o_busy    = w_stream;
   assign o_row     = w_stream ? r_row : '0;
   assign o_last    = w_last;
   assign o_data    = w_stream ? w_row_data : '0;
   assign o_overrun = r_overrun;

endmodule
